// File: rtl/mem_rd_latency_meter.sv
// Read-latency meter for a pipelined Avalon-MM master. It only snoops the bus.
// Each accepted read burst gets a timestamp in a small FIFO. The first returned
// word of the head burst produces a latency sample, which feeds min/max/sum
// statistics. Request and word counters are kept alongside.
// Optional histogram of latencies: define MEM_RD_LAT_HIST_EN.
module mem_rd_latency_meter #(
    parameter int unsigned AMM_BURST_W     = 11,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned DELAY_W         = 16,
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned HIST_BINS       = 16,
    parameter int unsigned HIST_SHIFT      = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_test_i,
    input  logic                         read_i,
    input  logic                         waitrequest_i,
    input  logic [AMM_BURST_W-1:0]       burstcount_i,
    input  logic                         readdatavalid_i,
    output logic                         meas_busy_o,
    output logic [CNT_W-1:0]             rd_req_amount_o,
    output logic [CNT_W-1:0]             rd_words_o,
    output logic [DELAY_W-1:0]           min_delay_o,
    output logic [DELAY_W-1:0]           max_delay_o,
    output logic [CNT_W-1:0]             sum_delay_o,
    output logic                         overflow_o,
    output logic                         unexpected_o,
    input  logic [$clog2(HIST_BINS)-1:0] hist_sel_i,
    output logic [CNT_W-1:0]             hist_cnt_o
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [DELAY_W-1:0]     ts_q;
    logic [DELAY_W-1:0]     ts_mem [MAX_OUTSTANDING];
    logic [AMM_BURST_W-1:0] bc_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    // Words already received for the head burst; zero means the next word is the first.
    logic [AMM_BURST_W-1:0] head_done_q, head_done_d;
    logic [CNT_W-1:0]       req_q, req_d, words_q, words_d, sum_q, sum_d;
    logic [DELAY_W-1:0]     min_q, min_d, max_q, max_d;
    logic                   ovf_q, ovf_d, unexp_q, unexp_d;

    logic                   accept, empty, full, head_first, pop, push;
    logic [DELAY_W-1:0]     latency;
    logic [AMM_BURST_W-1:0] burst_len;
    logic [CNT_W:0]         sum_ext;

    assign accept     = read_i & ~waitrequest_i;
    assign empty      = (count_q == '0);
    assign full       = (count_q == (PTR_W+1)'(MAX_OUTSTANDING));
    assign head_first = readdatavalid_i & ~empty & (head_done_q == '0);
    assign pop        = readdatavalid_i & ~empty &
                        ((head_done_q + AMM_BURST_W'(1)) == bc_mem[rd_ptr_q]);
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign push       = accept & (~full | pop);
    assign latency    = ts_q - ts_mem[rd_ptr_q];
    assign burst_len  = (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;
    assign sum_ext    = {1'b0, sum_q} + (CNT_W+1)'(latency);

    // Next-state for FIFO bookkeeping, counters, statistics and sticky flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        head_done_d = head_done_q;
        req_d       = req_q;
        words_d     = words_q;
        sum_d       = sum_q;
        min_d       = min_q;
        max_d       = max_q;
        ovf_d       = ovf_q;
        unexp_d     = unexp_q;
        if (start_test_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            head_done_d = '0;
            req_d       = '0;
            words_d     = '0;
            sum_d       = '0;
            min_d       = '1;
            max_d       = '0;
            ovf_d       = 1'b0;
            unexp_d     = 1'b0;
        end else begin
            if (accept) req_d = sat_inc(req_q);
            if (accept && !push) ovf_d = 1'b1;
            if (readdatavalid_i) words_d = sat_inc(words_q);
            if (readdatavalid_i && empty) unexp_d = 1'b1;
            if (readdatavalid_i && !empty) head_done_d = head_done_q + AMM_BURST_W'(1);
            if (pop) begin
                head_done_d = '0;
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            if (head_first) begin
                if (latency < min_q) min_d = latency;
                if (latency > max_q) max_d = latency;
                sum_d = sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
            end
        end
    end

    // State registers; the timestamp is only cleared by the hardware reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ts_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_done_q <= '0;
            req_q       <= '0;
            words_q     <= '0;
            sum_q       <= '0;
            min_q       <= '1;
            max_q       <= '0;
            ovf_q       <= 1'b0;
            unexp_q     <= 1'b0;
        end else begin
            ts_q        <= ts_q + DELAY_W'(1);
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_done_q <= head_done_d;
            req_q       <= req_d;
            words_q     <= words_d;
            sum_q       <= sum_d;
            min_q       <= min_d;
            max_q       <= max_d;
            ovf_q       <= ovf_d;
            unexp_q     <= unexp_d;
        end
    end

    // FIFO storage; contents beyond count_q are don't-care, so no reset.
    always_ff @(posedge clk_i) begin
        if (push && !start_test_i) begin
            ts_mem[wr_ptr_q] <= ts_q;
            bc_mem[wr_ptr_q] <= burst_len;
        end
    end

    assign meas_busy_o     = ~empty;
    assign rd_req_amount_o = req_q;
    assign rd_words_o      = words_q;
    assign min_delay_o     = min_q;
    assign max_delay_o     = max_q;
    assign sum_delay_o     = sum_q;
    assign overflow_o      = ovf_q;
    assign unexpected_o    = unexp_q;

`ifdef MEM_RD_LAT_HIST_EN
    localparam int unsigned BIN_W = $clog2(HIST_BINS);

    logic [CNT_W-1:0]   hist_q [HIST_BINS];
    logic [CNT_W-1:0]   hist_cnt_q;
    logic [DELAY_W-1:0] lat_shift;
    logic [BIN_W-1:0]   bin;

    assign lat_shift = latency >> HIST_SHIFT;
    assign bin       = (lat_shift > DELAY_W'(HIST_BINS - 1)) ? BIN_W'(HIST_BINS - 1) :
                                                                lat_shift[BIN_W-1:0];

    // Histogram bins bump on the same edge as min/max; readback is registered.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(HIST_BINS); i++) hist_q[i] <= '0;
            hist_cnt_q <= '0;
        end else if (start_test_i) begin
            for (int i = 0; i < int'(HIST_BINS); i++) hist_q[i] <= '0;
            hist_cnt_q <= '0;
        end else begin
            if (head_first) hist_q[bin] <= sat_inc(hist_q[bin]);
            hist_cnt_q <= hist_q[hist_sel_i];
        end
    end

    assign hist_cnt_o = hist_cnt_q;
`else
    logic unused_hist_sel;
    assign unused_hist_sel = ^hist_sel_i;
    assign hist_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_mem_rd_latency_meter.sv
// Directed bench for mem_rd_latency_meter with a queue-based reference model.
module tb_mem_rd_latency_meter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_test_i, read_i, waitrequest_i, readdatavalid_i;
    logic [10:0] burstcount_i;
    logic [3:0]  hist_sel_i;
    logic        meas_busy_o, overflow_o, unexpected_o;
    logic [31:0] rd_req_amount_o, rd_words_o, sum_delay_o, hist_cnt_o;
    logic [15:0] min_delay_o, max_delay_o;

    mem_rd_latency_meter dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_test_i    (start_test_i),
        .read_i          (read_i),
        .waitrequest_i   (waitrequest_i),
        .burstcount_i    (burstcount_i),
        .readdatavalid_i (readdatavalid_i),
        .meas_busy_o     (meas_busy_o),
        .rd_req_amount_o (rd_req_amount_o),
        .rd_words_o      (rd_words_o),
        .min_delay_o     (min_delay_o),
        .max_delay_o     (max_delay_o),
        .sum_delay_o     (sum_delay_o),
        .overflow_o      (overflow_o),
        .unexpected_o    (unexpected_o),
        .hist_sel_i      (hist_sel_i),
        .hist_cnt_o      (hist_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int passed = 0;
    int total  = 0;

    // Reference model: pending accept times and burst lengths, plus statistics.
    int          ts_sb[$];
    int          bc_sb[$];
    int          head_done;
    int          tick;
    int          m_req, m_words, m_sum, m_max, m_min;
    bit          m_ovf, m_unexp;
    int          m_hist[16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_clear();
        ts_sb.delete();
        bc_sb.delete();
        head_done = 0;
        m_req = 0; m_words = 0; m_sum = 0; m_max = 0; m_min = 65535;
        m_ovf = 0; m_unexp = 0;
        for (int i = 0; i < 16; i++) m_hist[i] = 0;
    endtask

    // Drive one cycle of stimulus, predict its effect, then sample 1 time unit after the edge.
    task automatic cycle(input bit rd, input int bc, input bit rdv, input bit st);
        bit was_full;
        bit popped;
        int lat;
        int b;
        was_full = (ts_sb.size() == 8);
        popped   = 0;
        if (st) begin
            model_clear();
        end else begin
            if (rdv) begin
                m_words++;
                if (ts_sb.size() == 0) begin
                    m_unexp = 1;
                end else begin
                    if (head_done == 0) begin
                        lat = tick - ts_sb[0];
                        if (lat < m_min) m_min = lat;
                        if (lat > m_max) m_max = lat;
                        m_sum += lat;
                        b = lat >> 2;
                        if (b > 15) b = 15;
                        m_hist[b]++;
                    end
                    head_done++;
                    if (head_done == bc_sb[0]) begin
                        void'(ts_sb.pop_front());
                        void'(bc_sb.pop_front());
                        head_done = 0;
                        popped = 1;
                    end
                end
            end
            if (rd) begin
                m_req++;
                if (was_full && !popped) begin
                    m_ovf = 1;
                end else begin
                    ts_sb.push_back(tick);
                    bc_sb.push_back((bc == 0) ? 1 : bc);
                end
            end
        end
        read_i          = rd;
        burstcount_i    = 11'(bc);
        readdatavalid_i = rdv;
        start_test_i    = st;
        @(posedge clk_i);
        #1;
        tick++;
        read_i = 0; readdatavalid_i = 0; start_test_i = 0; burstcount_i = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_busy"},  meas_busy_o,     ts_sb.size() != 0);
        chk({tag, "_req"},   rd_req_amount_o, m_req);
        chk({tag, "_words"}, rd_words_o,      m_words);
        chk({tag, "_min"},   min_delay_o,     m_min);
        chk({tag, "_max"},   max_delay_o,     m_max);
        chk({tag, "_sum"},   sum_delay_o,     m_sum);
        chk({tag, "_ovf"},   overflow_o,      m_ovf);
        chk({tag, "_unexp"}, unexpected_o,    m_unexp);
    endtask

    initial begin
        rst_i = 0; start_test_i = 0; read_i = 0; waitrequest_i = 0;
        burstcount_i = '0; readdatavalid_i = 0; hist_sel_i = '0;
        tick = 0;
        model_clear();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1;

        // Reset state after 10 idle cycles.
        idle(10);
        check_all("reset");
        chk("reset_min_const", min_delay_o, 16'hFFFF);

        // One burst of 4: latency 5.
        cycle(1, 4, 0, 0);
        idle(4);
        chk("burst_busy_mid", meas_busy_o, 1'b1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
        check_all("burst4");
        chk("burst4_min_const", min_delay_o, 16'd5);
        chk("burst4_sum_const", sum_delay_o, 32'd5);

        // Eight single-word reads, responses on odd cycles 3..17.
        cycle(0, 0, 0, 1);
        for (int t = 0; t < 18; t++)
            cycle(t < 8, 1, (t >= 3) && (t % 2 == 1), 0);
        check_all("singles");
        chk("singles_min_const", min_delay_o, 16'd3);
        chk("singles_max_const", max_delay_o, 16'd10);
        chk("singles_sum_const", sum_delay_o, 32'd52);

        // Ninth accept into a full FIFO with no pop: dropped and flagged.
        cycle(0, 0, 0, 1);
        for (int t = 0; t < 9; t++) cycle(1, 0, 0, 0);
        chk("ovf_flag", overflow_o, 1'b1);
        chk("ovf_req_const", rd_req_amount_o, 32'd9);
        for (int t = 0; t < 10; t++) cycle(0, 0, 1, 0);
        check_all("ovf_drain");

        // Full FIFO with a coincident pop accepts the new request.
        cycle(0, 0, 0, 1);
        for (int t = 0; t < 8; t++) cycle(1, 1, 0, 0);
        cycle(1, 2, 1, 0);
        chk("full_pop_ovf", overflow_o, 1'b0);
        for (int t = 0; t < 9; t++) cycle(0, 0, 1, 0);
        check_all("full_pop_drain");

        // Response with nothing outstanding.
        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        check_all("unexp");
        chk("unexp_words_const", rd_words_o, 32'd1);

        // start_test beats a same-cycle accept.
        cycle(1, 3, 0, 0);
        cycle(1, 2, 1, 1);
        check_all("start_prio");
        chk("start_prio_req_const", rd_req_amount_o, 32'd0);
        idle(2);
        chk("start_prio_busy", meas_busy_o, 1'b0);

        // Histogram: latencies 5, 6, 100.
        cycle(0, 0, 0, 1);
        cycle(1, 1, 0, 0); idle(4);  cycle(0, 0, 1, 0);
        cycle(1, 1, 0, 0); idle(5);  cycle(0, 0, 1, 0);
        cycle(1, 1, 0, 0); idle(99); cycle(0, 0, 1, 0);
        check_all("hist_stats");
        for (int s = 0; s < 16; s++) begin
            hist_sel_i = 4'(s);
            idle(2);
`ifdef MEM_RD_LAT_HIST_EN
            chk($sformatf("hist_bin%0d", s), hist_cnt_o, m_hist[s]);
`else
            chk($sformatf("hist_off%0d", s), hist_cnt_o, 0);
`endif
        end
`ifdef MEM_RD_LAT_HIST_EN
        hist_sel_i = 4'd1;  idle(2);
        chk("hist_bin1_const", hist_cnt_o, 32'd2);
        hist_sel_i = 4'd15; idle(2);
        chk("hist_bin15_const", hist_cnt_o, 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
